project7: RTL and testbench



---
 rtl/project7.sv | 129 ++++++++++++
 tb/tb_project7.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/project7.sv
// project7 -- WIDTH-bit binary adder with carry-in/carry-out plus a
// one-cycle registered output stage carrying sum, carry and status flags.
//
// Build option:
//   PROJECT7_CLA_EN  defined   : carries come from 4-bit carry-lookahead
//                                blocks (two-level form), rippled between
//                                nibbles.
//                    undefined : ripple-carry full-adder chain.
//   Both builds produce bit-identical outputs; only the carry structure differs.
//
// Ports:
//   clk     in   1      rising-edge clock (registered stage only)
//   rst     in   1      asynchronous active-high reset (registered stage only)
//   a       in   WIDTH  operand A
//   b       in   WIDTH  operand B
//   cin     in   1      carry-in
//   s       out  WIDTH  combinational sum (a + b + cin) mod 2^WIDTH
//   cout    out  1      combinational carry-out
//   s_q     out  WIDTH  registered s
//   cout_q  out  1      registered cout
//   ovf_q   out  1      registered signed overflow
//   zero_q  out  1      registered (s == 0)

module project7 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic [WIDTH-1:0] s_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             zero_q
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    assign g = a & b;
    assign p = a ^ b;
    assign c[0] = cin;

`ifdef PROJECT7_CLA_EN
    localparam int NIB   = (WIDTH + 3) / 4;
    localparam int PAD_W = NIB * 4;

    // Generate/propagate padded to whole nibbles; padding bits neither
    // generate nor propagate, so carries above WIDTH are simply ignored.
    logic [PAD_W-1:0] g_pad;
    logic [PAD_W-1:0] p_pad;
    logic [PAD_W:0]   c_pad;

    always_comb begin
        g_pad = '0;
        p_pad = '0;
        for (int i = 0; i < WIDTH; i++) begin
            g_pad[i] = g[i];
            p_pad[i] = p[i];
        end
    end

    assign c_pad[0] = cin;

    for (genvar n = 0; n < NIB; n++) begin : g_cla
        localparam int B = 4 * n;
        logic [3:0] gn;
        logic [3:0] pn;
        logic       cn;

        assign gn = g_pad[B+3:B];
        assign pn = p_pad[B+3:B];
        assign cn = c_pad[B];

        assign c_pad[B+1] = gn[0]
                          | (pn[0] & cn);
        assign c_pad[B+2] = gn[1]
                          | (pn[1] & gn[0])
                          | (pn[1] & pn[0] & cn);
        assign c_pad[B+3] = gn[2]
                          | (pn[2] & gn[1])
                          | (pn[2] & pn[1] & gn[0])
                          | (pn[2] & pn[1] & pn[0] & cn);
        assign c_pad[B+4] = gn[3]
                          | (pn[3] & gn[2])
                          | (pn[3] & pn[2] & gn[1])
                          | (pn[3] & pn[2] & pn[1] & gn[0])
                          | (pn[3] & pn[2] & pn[1] & pn[0] & cn);
    end

    assign c[WIDTH:1] = c_pad[WIDTH:1];
`else
    for (genvar i = 0; i < WIDTH; i++) begin : g_rca
        assign c[i+1] = g[i] | (p[i] & c[i]);
    end
`endif

    assign s    = p ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];

    logic ovf_d;
    logic zero_d;

    // Overflow only when both operands share a sign and the result does not.
    assign ovf_d  = (a[MSB] == b[MSB]) && (s[MSB] != a[MSB]);
    assign zero_d = (s == '0);

    // Registered stage: captures every cycle; reset state equals 0 + 0 + 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            s_q    <= s;
            cout_q <= cout;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

endmodule

// File: tb/tb_project7.sv
module tb_project7;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       cout;
    logic [3:0] s_q;
    logic       cout_q;
    logic       ovf_q;
    logic       zero_q;

    int checks;
    int failures;

    project7 #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .s      (s),
        .cout   (cout),
        .s_q    (s_q),
        .cout_q (cout_q),
        .ovf_q  (ovf_q),
        .zero_q (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       cout;
        logic       ovf;
        logic       zero;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] va, input logic [3:0] vb, input logic vc);
        @(negedge clk);
        a   = va;
        b   = vb;
        cin = vc;
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [3:0] es, input logic ec,
                              input logic eo, input logic ez);
        check({tag, " s_q"},    {28'd0, s_q},    {28'd0, es});
        check({tag, " cout_q"}, {31'd0, cout_q}, {31'd0, ec});
        check({tag, " ovf_q"},  {31'd0, ovf_q},  {31'd0, eo});
        check({tag, " zero_q"}, {31'd0, zero_q}, {31'd0, ez});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        a   = 4'h0;
        b   = 4'h0;
        cin = 1'b0;

        //            a      b      cin   s      cout  ovf   zero
        vecs[0] = '{4'h1, 4'h0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'h2, 4'h4, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{4'hB, 4'h6, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{4'h5, 4'h3, 1'b1, 4'h9, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1};

        // Reset state, held across clock edges.
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset", 4'h0, 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].cin);
            check($sformatf("vec%0d s", i),    {28'd0, s},    {28'd0, vecs[i].s});
            check($sformatf("vec%0d cout", i), {31'd0, cout}, {31'd0, vecs[i].cout});
            @(posedge clk);
            #1;
            check_regs($sformatf("vec%0d", i), vecs[i].s, vecs[i].cout, vecs[i].ovf, vecs[i].zero);
        end

        // Exhaustive sweep against an arithmetic model.
        for (int k = 0; k < 512; k++) begin
            logic [3:0] ta;
            logic [3:0] tb;
            logic       tc;
            logic [4:0] full;
            int         sa;
            int         sb;
            int         ssum;
            logic       eovf;
            ta = k[8:5];
            tb = k[4:1];
            tc = k[0];
            full = {1'b0, ta} + {1'b0, tb} + {4'd0, tc};
            sa = ta[3] ? int'(ta) - 16 : int'(ta);
            sb = tb[3] ? int'(tb) - 16 : int'(tb);
            ssum = sa + sb + int'(tc);
            eovf = (ssum > 7) || (ssum < -8);
            drive(ta, tb, tc);
            check($sformatf("sweep%0d sum", k), {27'd0, cout, s}, {27'd0, full});
            @(posedge clk);
            #1;
            check($sformatf("sweep%0d regs", k),
                  {25'd0, cout_q, s_q, ovf_q, zero_q},
                  {25'd0, full[4], full[3:0], eovf, (full[3:0] == 4'h0)});
        end

        // Asynchronous reset between edges.
        drive(4'hF, 4'hF, 1'b0);
        @(posedge clk);
        #1;
        check_regs("preload", 4'hE, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_regs("async_rst", 4'h0, 1'b0, 1'b0, 1'b1);
        check("async_rst s",    {28'd0, s},    32'hE);
        check("async_rst cout", {31'd0, cout}, 32'h1);
        rst = 1'b0;
        #1;
        check_regs("post_rst_hold", 4'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_regs("recapture", 4'hE, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
